// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction-fetch stage: PC, IF/ID register, redirect/stall/flush, fetch fault halt
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 4096,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] imem_addr_o,
    input  logic [31:0] imem_instr_i,
    output logic        if_id_valid_o,
    output logic [31:0] if_id_instr_o,
    output logic [31:0] if_id_pc_o,
    output logic [31:0] if_id_pc_plus4_o,
    output logic        fetch_fault_o
);

    localparam logic [0:0]  RUN    = 1'b0;
    localparam logic [0:0]  HALT   = 1'b1;
    localparam logic [31:0] PC_MAX = 32'(MEM_BYTES - 4);

    logic [0:0]  state_q;
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic        fault_c;
    logic        enter_halt;

    assign imem_addr_o = pc_q;
    assign pc_plus4    = pc_q + 32'd4;
    assign fault_c     = (pc_q[1:0] != 2'b00) || (pc_q > PC_MAX);
    // A fault only takes effect when the current fetch is not being held or redirected away.
    assign enter_halt  = (state_q == RUN) && fault_c && !stall_i && !redirect_i;

    // Program counter and RUN/HALT state; HALT is left only through reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
        end else if (state_q == RUN) begin
            if (redirect_i) begin
                pc_q <= redirect_pc_i;
            end else if (stall_i || fault_c) begin
                pc_q <= pc_q;
            end else begin
                pc_q <= pc_plus4;
            end
            if (enter_halt) begin
                state_q <= HALT;
            end
        end
    end

    // IF/ID pipeline register and the sticky fault flag; faulting words are bubbled, never captured.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            if_id_valid_o    <= 1'b0;
            if_id_instr_o    <= NOP_INSTR;
            if_id_pc_o       <= 32'd0;
            if_id_pc_plus4_o <= 32'd4;
            fetch_fault_o    <= 1'b0;
        end else if (state_q == HALT) begin
            if_id_valid_o <= 1'b0;
            if_id_instr_o <= NOP_INSTR;
        end else begin
            if (redirect_i || flush_i) begin
                if_id_valid_o <= 1'b0;
                if_id_instr_o <= NOP_INSTR;
            end else if (stall_i) begin
                if_id_valid_o <= if_id_valid_o;
            end else if (fault_c) begin
                if_id_valid_o <= 1'b0;
                if_id_instr_o <= NOP_INSTR;
            end else begin
                if_id_valid_o    <= 1'b1;
                if_id_instr_o    <= imem_instr_i;
                if_id_pc_o       <= pc_q;
                if_id_pc_plus4_o <= pc_plus4;
            end
            if (enter_halt) begin
                fetch_fault_o <= 1'b1;
            end
        end
    end

endmodule
